// File: rtl/write_back_buffer.sv
`default_nettype none
// ============================================================================
// Module   : write_back_buffer
// Brief    : Holds one evicted dirty line and writes it out as an AXI3 INCR
//            burst, with a same-cycle hazard check for dcache misses.
// Revision : 1.0 - initial release
// ============================================================================
module write_back_buffer #(
    parameter int BURST_LENGTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_req,
    input  logic [31:0]  wb_addr,
    input  logic [511:0] wb_line,
    output logic         wb_ack,
    output logic         buff_busy,
    input  logic [31:0]  query_addr,
    output logic         query_hit,
    output logic [3:0]   awid,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic [31:0]  awaddr,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [3:0] c_LAST_BEAT = 4'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t         state_q;
    logic [31:0]    addr_q;
    logic [511:0]   line_q;
    logic [3:0]     count_q;
    logic           awvalid_q;
    logic           wvalid_q;
    logic           bready_q;

    // Write response content is deliberately dropped: no retry on error.
    logic unused_ok;
    assign unused_ok = ^{bid, bresp, wb_addr[5:0], query_addr[5:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_req) begin
                        addr_q    <= {wb_addr[31:6], 6'b0};
                        line_q    <= wb_line;
                        awvalid_q <= 1'b1;
                        state_q   <= S_AW;
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        count_q   <= '0;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (count_q == c_LAST_BEAT) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            count_q  <= '0;
                            state_q  <= S_B;
                        end else begin
                            count_q <= count_q + 4'd1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_ack    = (state_q == S_IDLE) && wb_req;
    assign buff_busy = (state_q != S_IDLE);
    assign query_hit = buff_busy && (query_addr[31:6] == addr_q[31:6]);

    assign awid    = 4'd0;
    assign awlen   = 8'(BURST_LENGTH - 1);
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd0;
    assign wstrb   = 4'b1111;

    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    // Beat data is gated so the bus reads zero outside the data phase.
    assign wdata   = wvalid_q ? line_q[{count_q, 5'b0} +: 32] : 32'd0;
    assign wlast   = wvalid_q && (count_q == c_LAST_BEAT);

endmodule
`default_nettype wire
